// File: rtl/rx_unstuff_deser_if.sv
// Receive deserializer bus: qualified serial bits in, completed words and stuffing events out.
interface rx_unstuff_deser_if #(
   parameter int unsigned WIDTH = 8
);
   logic             bitIn;
   logic             bitValid;
   logic             clear;
   logic [WIDTH-1:0] dataOut;
   logic             dataValid;
   logic             stuffSkip;
   logic             stuffErr;

   modport master (
      output bitIn, bitValid, clear,
      input  dataOut, dataValid, stuffSkip, stuffErr
   );

   modport slave (
      input  bitIn, bitValid, clear,
      output dataOut, dataValid, stuffSkip, stuffErr
   );
endinterface

// File: rtl/rx_unstuff_deser.sv
// Receive-side deserializer: optional NRZI decode, bit-unstuffing with violation detect,
// and serial-to-parallel word assembly with a one-cycle valid strobe.
module rx_unstuff_deser #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned STUFF_LEN = 6,
   parameter bit          NRZI      = 1'b0,
   parameter bit          LSB_FIRST = 1'b1
) (
   input logic              clk,
   input logic              rst,
   rx_unstuff_deser_if.slave bus
);
   localparam int unsigned CntW  = $clog2(WIDTH + 1);
   localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);

   logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [OnesW-1:0] ones_q, ones_d;
   logic             prev_q, prev_d;
   logic             dv_q, dv_d;
   logic             skip_q, skip_d;
   logic             err_q, err_d;
   logic             d_bit;

   always_comb begin
      d_bit = NRZI ? ~(bus.bitIn ^ prev_q) : bus.bitIn;
      if (LSB_FIRST) sr_shift = {d_bit, sr_q[WIDTH-1:1]};
      else           sr_shift = {sr_q[WIDTH-2:0], d_bit};
   end

   always_comb begin
      sr_d   = sr_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      ones_d = ones_q;
      prev_d = prev_q;
      dv_d   = 1'b0;
      skip_d = 1'b0;
      err_d  = 1'b0;
      if (bus.clear) begin
         // Re-align drops any bit presented in the same cycle.
         sr_d   = '0;
         cnt_d  = '0;
         ones_d = '0;
         prev_d = 1'b1;
      end else if (bus.bitValid) begin
         prev_d = bus.bitIn;
         if (ones_q == OnesW'(STUFF_LEN)) begin
            ones_d = '0;
            if (d_bit) begin
               err_d = 1'b1;
               sr_d  = '0;
               cnt_d = '0;
            end else begin
               skip_d = 1'b1;
            end
         end else begin
            sr_d   = sr_shift;
            ones_d = d_bit ? ones_q + 1'b1 : '0;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               data_d = sr_shift;
               dv_d   = 1'b1;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q   <= '0;
         data_q <= '0;
         cnt_q  <= '0;
         ones_q <= '0;
         prev_q <= 1'b1;
         dv_q   <= 1'b0;
         skip_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
         ones_q <= ones_d;
         prev_q <= prev_d;
         dv_q   <= dv_d;
         skip_q <= skip_d;
         err_q  <= err_d;
      end
   end

   assign bus.dataOut   = data_q;
   assign bus.dataValid = dv_q;
   assign bus.stuffSkip = skip_q;
   assign bus.stuffErr  = err_q;
endmodule

// File: tb/tb_rx_unstuff_deser.sv
// Directed bench: a plain-binary LSB-first instance driven from a vector table plus
// hand sequences, and an NRZI instance for line-decoding cases.
module tb_rx_unstuff_deser;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rx_unstuff_deser_if #(.WIDTH(8)) bus0 ();
   rx_unstuff_deser_if #(.WIDTH(8)) bus1 ();

   rx_unstuff_deser #(.WIDTH(8), .STUFF_LEN(6), .NRZI(1'b0), .LSB_FIRST(1'b1)) u_bin (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   rx_unstuff_deser #(.WIDTH(8), .STUFF_LEN(6), .NRZI(1'b1), .LSB_FIRST(1'b1)) u_nrzi (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   typedef struct {
      logic [31:0] bits;    // bit i is sent i-th
      int          n;
      int          data;
      int          ndv;
      int          dv_at;   // 1-based index of last pulse, 0 if none
      int          nskip;
      int          skip_at;
      int          nerr;
      int          err_at;
   } vec_t;

   vec_t vecs[6];
   int checks = 0;
   int failures = 0;
   int n_dv, dv_at, n_skip, skip_at, n_err, err_at, n_both;
   logic s_dv, s_skip, s_err;
   logic [7:0] s_data;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step(input bit sel, input logic b, input logic v, input logic c);
      @(negedge clk);
      bus0.bitIn = 1'b0; bus0.bitValid = 1'b0; bus0.clear = 1'b0;
      bus1.bitIn = 1'b0; bus1.bitValid = 1'b0; bus1.clear = 1'b0;
      if (sel) begin
         bus1.bitIn = b; bus1.bitValid = v; bus1.clear = c;
      end else begin
         bus0.bitIn = b; bus0.bitValid = v; bus0.clear = c;
      end
      @(posedge clk);
      #1;
      s_dv   = sel ? bus1.dataValid : bus0.dataValid;
      s_skip = sel ? bus1.stuffSkip : bus0.stuffSkip;
      s_err  = sel ? bus1.stuffErr  : bus0.stuffErr;
      s_data = sel ? bus1.dataOut   : bus0.dataOut;
      bus0.bitValid = 1'b0; bus0.clear = 1'b0;
      bus1.bitValid = 1'b0; bus1.clear = 1'b0;
   endtask

   task automatic send(input bit sel, input logic [31:0] bits, input int n);
      n_dv = 0; dv_at = 0; n_skip = 0; skip_at = 0; n_err = 0; err_at = 0; n_both = 0;
      for (int i = 0; i < n; i++) begin
         step(sel, bits[i], 1'b1, 1'b0);
         if (s_dv)   begin n_dv++;   dv_at = i + 1;   end
         if (s_skip) begin n_skip++; skip_at = i + 1; end
         if (s_err)  begin n_err++;  err_at = i + 1;  end
         if ((s_dv && s_skip) || (s_dv && s_err)) n_both++;
      end
   endtask

   task automatic idle_check(input bit sel, input string name);
      step(sel, 1'b0, 1'b0, 1'b0);
      check(name, int'({s_dv, s_skip, s_err}), 0);
   endtask

   initial begin
      vecs[0] = '{32'h000000A5,  8, 'hA5, 1,  8, 0,  0, 0, 0};
      vecs[1] = '{32'h0000003F,  9, 'h3F, 1,  9, 1,  7, 0, 0};
      vecs[2] = '{32'h00001FBF, 18, 'h0F, 2, 18, 2, 14, 0, 0};
      vecs[3] = '{32'h0000007F, 15, 'h00, 1, 15, 0,  0, 1, 7};
      vecs[4] = '{32'h000000FC, 17, 'h00, 2, 17, 1,  9, 0, 0};
      vecs[5] = '{32'h0000001F,  8, 'h1F, 1,  8, 0,  0, 0, 0};

      bus0.bitIn = 1'b0; bus0.bitValid = 1'b0; bus0.clear = 1'b0;
      bus1.bitIn = 1'b0; bus1.bitValid = 1'b0; bus1.clear = 1'b0;
      #3;
      check("reset_data0", int'(bus0.dataOut), 0);
      check("reset_pulses0", int'({bus0.dataValid, bus0.stuffSkip, bus0.stuffErr}), 0);
      check("reset_data1", int'(bus1.dataOut), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         send(1'b0, vecs[i].bits, vecs[i].n);
         check($sformatf("v%0d_data", i), int'(s_data), vecs[i].data);
         check($sformatf("v%0d_ndv", i), n_dv, vecs[i].ndv);
         check($sformatf("v%0d_dv_at", i), dv_at, vecs[i].dv_at);
         check($sformatf("v%0d_nskip", i), n_skip, vecs[i].nskip);
         check($sformatf("v%0d_skip_at", i), skip_at, vecs[i].skip_at);
         check($sformatf("v%0d_nerr", i), n_err, vecs[i].nerr);
         check($sformatf("v%0d_err_at", i), err_at, vecs[i].err_at);
         check($sformatf("v%0d_overlap", i), n_both, 0);
      end

      // Gap: half a word, idle cycles, second half.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      send(1'b0, 32'h5, 4);
      check("gap_first_half_ndv", n_dv, 0);
      for (int i = 0; i < 5; i++) idle_check(1'b0, "gap_idle_pulses");
      send(1'b0, 32'hA, 4);
      check("gap_data", int'(s_data), 'hA5);
      check("gap_dv_at", dv_at, 4);

      // Clear with a simultaneous valid 1 after five ones: must drop the bit and the run.
      send(1'b0, 32'h1F, 5);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("clear_pulses", int'({s_dv, s_skip, s_err}), 0);
      check("clear_keeps_data", int'(s_data), 'hA5);
      send(1'b0, 32'h03, 8);
      check("clear_w1_data", int'(s_data), 'h03);
      check("clear_w1_err", n_err, 0);
      check("clear_w1_dv_at", dv_at, 8);
      send(1'b0, 32'h5A, 8);
      check("clear_w2_data", int'(s_data), 'h5A);
      check("clear_w2_dv_at", dv_at, 8);

      // Asynchronous reset while a dataValid pulse is showing.
      send(1'b0, 32'h25, 7);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("prerst_dv", int'(s_dv), 1);
      check("prerst_data", int'(s_data), 'hA5);
      rst = 1'b1;
      #1;
      check("rst_async_data", int'(bus0.dataOut), 0);
      check("rst_async_dv", int'(bus0.dataValid), 0);
      @(negedge clk);
      rst = 1'b0;
      send(1'b0, 32'h5A, 8);
      check("postrst_data", int'(s_data), 'h5A);
      check("postrst_dv_at", dv_at, 8);

      // NRZI: transition every bit from idle J decodes to all zeros.
      send(1'b1, 32'hAA, 8);
      check("nrzi_zero_data", int'(s_data), 0);
      check("nrzi_zero_dv_at", dv_at, 8);
      check("nrzi_zero_skip", n_skip, 0);
      // Line held low: decoded 0 then seven ones, the seventh hits the stuff slot.
      send(1'b1, 32'h00, 8);
      check("nrzi_err_n", n_err, 1);
      check("nrzi_err_at", err_at, 8);
      check("nrzi_err_ndv", n_dv, 0);
      // Decoded 0xA5 starting from prevLine=0.
      send(1'b1, 32'h36, 8);
      check("nrzi_a5_data", int'(s_data), 'hA5);
      check("nrzi_a5_dv_at", dv_at, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
